// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_t;

  localparam logic [7:0]  PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_BREAK = 8'hF0;
  localparam int unsigned PS2_DATA_BITS    = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioning: 2-FF synchronizers on both lines, a glitch filter and
// falling-edge detector on the clock line.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign data_o = data_sync_q[1];

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_o = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
        fall_o = filt_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 receive FSM: frames scan-code bytes, folds E0/F0 prefixes into flags and
// emits one key event per keystroke, with a frame/prefix timeout.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       frame_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall, data;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_filter (
    .clk_i      (clk),
    .rst_i      (rst),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_data_i (ps2_data_in),
    .fall_o     (fall),
    .data_o     (data)
  );

  ps2_state_t      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            valid_q, valid_d;
  logic [7:0]      code_q, code_d;
  logic            kext_q, kext_d;
  logic            kbrk_q, kbrk_d;
  logic            err_q, err_d;
  logic            tmo_hit, running;

  assign running = (state_q != StIdle) || ext_q || brk_q;
  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    tmo_d     = tmo_q;
    valid_d   = 1'b0;
    code_d    = code_q;
    kext_d    = kext_q;
    kbrk_d    = kbrk_q;
    err_d     = 1'b0;

    // Saturating idle counter; a falling edge always takes priority.
    if (fall || !running) begin
      tmo_d = '0;
    end else if (!tmo_hit) begin
      tmo_d = tmo_q + TmoW'(1);
    end

    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!data) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d = {data, shift_q[7:1]};
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
            state_d = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        StParity: begin
          parity_d = data;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if ((^shift_q ^ parity_q) && data) begin
            if (shift_q == PS2_PREFIX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BREAK) begin
              brk_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              code_d  = shift_q;
              kext_d  = ext_q;
              kbrk_d  = brk_q;
              ext_d   = 1'b0;
              brk_d   = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      endcase
    end else if (tmo_hit) begin
      // Abandon both a half-received frame and any dangling prefix.
      if (state_q != StIdle) begin
        state_d = StIdle;
        err_d   = 1'b1;
      end
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      tmo_q     <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      kext_q    <= 1'b0;
      kbrk_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      tmo_q     <= tmo_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      kext_q    <= kext_d;
      kbrk_q    <= kbrk_d;
      err_q     <= err_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_ext   = kext_q;
  assign key_break = kbrk_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed keystroke scenarios plus randomized frames
// checked against a byte-level keyboard model.
module tb_ps2_key_decoder;

  localparam int unsigned FilterLen = 8;
  localparam int unsigned Timeout   = 2000;
  localparam int unsigned Half      = 30;
  localparam int unsigned Gap       = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_valid, key_ext, key_break, frame_err;
  logic [7:0] key_code;

  ps2_key_decoder #(
    .FILTER_LEN     (FilterLen),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk),
    .ps2_data_in (ps2_data),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_break   (key_break),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;

  // Reference model state: held event fields and pending prefixes.
  logic [7:0] m_code;
  logic       m_ext, m_brk, m_pend_ext, m_pend_brk;

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) valid_cnt++;
      if (frame_err) err_cnt++;
      if (key_valid && frame_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(Half);
    ps2_clk = 1'b0;
    wait_cyc(Half);
    ps2_clk = 1'b1;
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
    m_pend_ext = 1'b0; m_pend_brk = 1'b0;
  endtask

  // Sends one frame, updates the model, and checks pulses and held fields.
  task automatic do_frame(input string tag, input logic [7:0] b,
                          input logic bad_par, input logic bad_stop);
    int v0, e0, exp_v, exp_e;
    v0 = valid_cnt; e0 = err_cnt;
    exp_v = 0; exp_e = 0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cyc(Gap);
    if (bad_par || bad_stop) begin
      exp_e = 1; m_pend_ext = 1'b0; m_pend_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_pend_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_pend_brk = 1'b1;
    end else begin
      exp_v = 1; m_code = b; m_ext = m_pend_ext; m_brk = m_pend_brk;
      m_pend_ext = 1'b0; m_pend_brk = 1'b0;
    end
    check({tag, ".valid_pulses"}, valid_cnt - v0, exp_v);
    check({tag, ".err_pulses"}, err_cnt - e0, exp_e);
    check({tag, ".key_code"}, {24'd0, key_code}, {24'd0, m_code});
    check({tag, ".key_ext"}, {31'd0, key_ext}, {31'd0, m_ext});
    check({tag, ".key_break"}, {31'd0, key_break}, {31'd0, m_brk});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".key_valid"}, {31'd0, key_valid}, 0);
    check({tag, ".key_code"}, {24'd0, key_code}, 0);
    check({tag, ".key_ext"}, {31'd0, key_ext}, 0);
    check({tag, ".key_break"}, {31'd0, key_break}, 0);
    check({tag, ".frame_err"}, {31'd0, frame_err}, 0);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] rb;
    logic bp, bs;
    model_reset();
    wait_cyc(4);
    check_outputs_zero("reset");
    rst = 1'b0;
    wait_cyc(20);

    do_frame("make_1c", 8'h1C, 1'b0, 1'b0);
    do_frame("brk_f0", 8'hF0, 1'b0, 1'b0);
    do_frame("brk_1c", 8'h1C, 1'b0, 1'b0);
    do_frame("xb_e0", 8'hE0, 1'b0, 1'b0);
    do_frame("xb_f0", 8'hF0, 1'b0, 1'b0);
    do_frame("xb_75", 8'h75, 1'b0, 1'b0);
    do_frame("after_29", 8'h29, 1'b0, 1'b0);
    do_frame("parity_err", 8'h1C, 1'b1, 1'b0);
    do_frame("stop_err", 8'h5A, 1'b0, 1'b1);
    do_frame("repeat_e0a", 8'hE0, 1'b0, 1'b0);
    do_frame("repeat_e0b", 8'hE0, 1'b0, 1'b0);
    do_frame("repeat_6b", 8'h6B, 1'b0, 1'b0);

    // Timeout: abandon after start + 4 data bits.
    v0 = valid_cnt; e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(Timeout + 10);
    check("timeout.err_pulses", err_cnt - e0, 1);
    check("timeout.valid_pulses", valid_cnt - v0, 0);
    do_frame("post_timeout_29", 8'h29, 1'b0, 1'b0);

    // Pending prefix expires silently.
    do_frame("stale_f0", 8'hF0, 1'b0, 1'b0);
    e0 = err_cnt;
    wait_cyc(Timeout + 10);
    check("stale_prefix.err_pulses", err_cnt - e0, 0);
    m_pend_brk = 1'b0;
    do_frame("after_stale_12", 8'h12, 1'b0, 1'b0);

    // Reset mid-frame after 4 bits.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rst = 1'b1;
    wait_cyc(3);
    check_outputs_zero("midreset");
    rst = 1'b0;
    ps2_data = 1'b1;
    model_reset();
    wait_cyc(20);
    do_frame("post_reset_1c", 8'h1C, 1'b0, 1'b0);

    // Short clock glitch with data low must not start a frame.
    v0 = valid_cnt; e0 = err_cnt;
    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(40);
    ps2_data = 1'b1;
    check("glitch.valid_pulses", valid_cnt - v0, 0);
    check("glitch.err_pulses", err_cnt - e0, 0);
    do_frame("post_glitch_1c", 8'h1C, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        default: rb = 8'($urandom);
      endcase
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 14) == 0);
      do_frame($sformatf("rand%0d", n), rb, bp, bs);
    end

    check("never_both_pulses", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
